// File: rtl/nq_bus_pkg.sv
// Shared definitions for the memory-bus arbiter: requester indices, FSM encodings
// and the modulo-3 successor used by the round-robin search.
package nq_bus_pkg;

    localparam int REQ_FETCH = 0;
    localparam int REQ_DATA  = 1;
    localparam int REQ_DBG   = 2;
    localparam int NREQ      = 3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_BUSY = 3'b010,
        ST_RESP = 3'b100
    } bus_state_t;

    // Successor in the ring 0 -> 1 -> 2 -> 0; an out-of-range index restarts at 0.
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        case (idx)
            2'd0:    rr_next = 2'd1;
            2'd1:    rr_next = 2'd2;
            default: rr_next = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational round-robin picker for three requesters: searches last+1, last+2, last.
module rr_pick3
    import nq_bus_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] last,
    output logic [1:0] gnt_idx,
    output logic       any
);

    logic [1:0] first_idx;
    logic [1:0] second_idx;

    always_comb begin
        first_idx  = rr_next(last);
        second_idx = rr_next(first_idx);
        any        = |req;
        gnt_idx    = last;
        if (req[first_idx]) begin
            gnt_idx = first_idx;
        end else if (req[second_idx]) begin
            gnt_idx = second_idx;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch, data and debug requesters,
// one transaction at a time, with a bus-hang timeout and a CPU stall output.
module mem_bus_arbiter
    import nq_bus_pkg::*;
#(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        req,
    input  logic [2:0]        we,
    input  logic [3*AW-1:0]   addr,
    input  logic [3*DW-1:0]   wdata,
    output logic [2:0]        ack,
    output logic [DW-1:0]     rdata,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    input  logic [DW-1:0]     mem_rdata,
    input  logic              mem_ack,
    output logic              need_wait,
    output logic [2:0]        dbg_state
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    bus_state_t     state_reg;
    bus_state_t     state_next;
    logic [1:0]     gnt_reg;
    logic [1:0]     last_reg;
    logic [AW-1:0]  addr_reg;
    logic [DW-1:0]  wdata_reg;
    logic           we_reg;
    logic [CW-1:0]  cnt_reg;
    logic [2:0]     ack_reg;
    logic [DW-1:0]  rdata_reg;
    logic           err_reg;

    logic [1:0]     pick_idx;
    logic           pick_any;
    logic           timed_out;
    logic [AW-1:0]  addr_arr  [NREQ];
    logic [DW-1:0]  wdata_arr [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = addr[gi*AW +: AW];
            assign wdata_arr[gi] = wdata[gi*DW +: DW];
        end
    endgenerate

    // A late mem_ack on the last allowed cycle still wins over the abort.
    generate
        if (TIMEOUT > 0) begin : g_timeout
            assign timed_out = (cnt_reg == CW'(TIMEOUT - 1)) && !mem_ack;
        end else begin : g_no_timeout
            assign timed_out = 1'b0;
        end
    endgenerate

    rr_pick3 u_pick (
        .req     (req),
        .last    (last_reg),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE: if (pick_any) state_next = ST_BUSY;
            ST_BUSY: if (mem_ack || timed_out) state_next = ST_RESP;
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_reg   <= 2'd0;
            last_reg  <= 2'd2;
            addr_reg  <= '0;
            wdata_reg <= '0;
            we_reg    <= 1'b0;
            cnt_reg   <= '0;
            ack_reg   <= '0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            if (state_reg == ST_IDLE && pick_any) begin
                gnt_reg   <= pick_idx;
                last_reg  <= pick_idx;
                addr_reg  <= addr_arr[pick_idx];
                wdata_reg <= wdata_arr[pick_idx];
                we_reg    <= (pick_idx != 2'(REQ_FETCH)) && we[pick_idx];
                cnt_reg   <= '0;
            end
            if (state_reg == ST_BUSY) begin
                if (cnt_reg != CW'(TIMEOUT)) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
                if (mem_ack) begin
                    rdata_reg <= mem_rdata;
                end else if (timed_out) begin
                    rdata_reg <= '0;
                end
                if (mem_ack || timed_out) begin
                    ack_reg <= 3'b001 << gnt_reg;
                    err_reg <= !mem_ack;
                end
            end
            if (state_reg == ST_RESP) begin
                ack_reg <= '0;
                err_reg <= 1'b0;
            end
        end
    end

    assign mem_req   = (state_reg == ST_BUSY);
    assign mem_we    = mem_req & we_reg;
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign ack       = ack_reg;
    assign rdata     = rdata_reg;
    assign err       = err_reg;
    assign dbg_state = state_reg;

    // The CPU is released in the ack cycle of its own access; debug never stalls it.
    assign need_wait = (req[REQ_FETCH] | req[REQ_DATA])
                     & ~((state_reg == ST_RESP) & (gnt_reg != 2'(REQ_DBG)) & req[gnt_reg]);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios then random traffic,
// checked cycle by cycle against a transaction timeline model.
module tb_mem_bus_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [2:0]        req;
    logic [2:0]        we;
    logic [3*AW-1:0]   addr;
    logic [3*DW-1:0]   wdata;
    logic [2:0]        ack;
    logic [DW-1:0]     rdata;
    logic              err;
    logic              mem_req;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata;
    logic              mem_ack;
    logic              need_wait;
    logic [2:0]        dbg_state;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .ack       (ack),
        .rdata     (rdata),
        .err       (err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .need_wait (need_wait),
        .dbg_state (dbg_state)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Requester side: payload held until ack, then policy 0=drop, 1=keep, 2=random.
    logic          r_req   [3];
    logic          r_we    [3];
    logic [AW-1:0] r_addr  [3];
    logic [DW-1:0] r_wdata [3];
    int            pol     [3];
    bit            rnd_on = 1'b0;

    // Timeline model of the current transaction, in absolute cycle numbers.
    int            t_start = -100;
    int            t_len   = 0;
    int            t_ackc  = -100;
    int            t_ackin = -1;
    int            next_free = 0;
    int            last_g  = 2;
    int            t_g     = 0;
    bit            t_to    = 1'b0;
    logic [AW-1:0] x_addr;
    logic          x_we;
    logic [DW-1:0] x_wdata;
    logic [DW-1:0] exp_rdata = '0;
    logic [DW-1:0] cap_rdata = '0;
    int            dly_q[$];
    logic [DW-1:0] rd_q[$];
    int            grants[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h cycle=%0d", tag, obs, expv, cyc);
        end
    endtask

    task automatic drive_ports();
        for (int i = 0; i < 3; i++) begin
            req[i]               = r_req[i];
            we[i]                = r_we[i];
            addr[i*AW +: AW]     = r_addr[i];
            wdata[i*DW +: DW]    = r_wdata[i];
        end
    endtask

    task automatic new_payload(input int i);
        r_addr[i]  = AW'($urandom);
        r_wdata[i] = DW'($urandom);
        r_we[i]    = 1'($urandom_range(0, 1));
    endtask

    function automatic bit any_req();
        return r_req[0] | r_req[1] | r_req[2];
    endfunction

    task automatic step();
        bit busy;
        bit resp;
        bit found;
        int d;
        logic [2:0] rv;
        @(posedge clk);
        cyc++;
        #1;
        drive_ports();
        rv = {r_req[2], r_req[1], r_req[0]};
        if (cyc >= next_free && rv != 3'b000) begin
            found = 1'b0;
            for (int k = 1; k <= 3; k++) begin
                if (!found && rv[(last_g + k) % 3]) begin
                    t_g   = (last_g + k) % 3;
                    found = 1'b1;
                end
            end
            last_g = t_g;
            if (dly_q.size() > 0) d = dly_q.pop_front();
            else d = int'($urandom_range(0, 9));
            t_start = cyc;
            if (d <= TO - 1) begin
                t_len = d + 1; t_to = 1'b0; t_ackin = cyc + 1 + d;
            end else begin
                t_len = TO; t_to = 1'b1; t_ackin = -1;
            end
            t_ackc    = cyc + t_len + 1;
            next_free = t_ackc + 1;
            x_addr    = r_addr[t_g];
            x_we      = (t_g != 0) && r_we[t_g];
            x_wdata   = r_wdata[t_g];
        end
        busy    = (cyc > t_start) && (cyc <= t_start + t_len);
        resp    = (cyc == t_ackc);
        mem_ack = (cyc == t_ackin);
        if (mem_ack && rd_q.size() > 0) mem_rdata = rd_q.pop_front();
        else mem_rdata = DW'($urandom);
        if (mem_ack) cap_rdata = mem_rdata;
        if (resp) exp_rdata = t_to ? '0 : cap_rdata;
        #1;
        chk("dbg_state", dbg_state, busy ? 3'b010 : (resp ? 3'b100 : 3'b001));
        chk("mem_req", mem_req, busy);
        if (busy) begin
            chk("mem_addr", mem_addr, x_addr);
            chk("mem_we", mem_we, x_we);
            chk("mem_wdata", mem_wdata, x_wdata);
        end
        chk("ack", ack, resp ? (3'b001 << t_g) : 3'b000);
        chk("err", err, resp && t_to);
        chk("rdata", rdata, exp_rdata);
        chk("need_wait", need_wait,
            (r_req[0] | r_req[1]) & ~(resp && t_g <= 1 && r_req[t_g]));
        if (resp) begin
            grants.push_back(t_g);
            $display("[TB] txn cycle=%0d grant=%0d addr=0x%04h we=%0d rdata=0x%04h err=%0d",
                     cyc, t_g, x_addr, x_we, exp_rdata, t_to);
            if (pol[t_g] == 0) begin
                r_req[t_g] = 1'b0;
            end else if (pol[t_g] == 2) begin
                if ($urandom_range(0, 1) == 0) r_req[t_g] = 1'b0;
                else new_payload(t_g);
            end
        end
        if (rnd_on) begin
            for (int i = 0; i < 3; i++) begin
                if (!r_req[i] && $urandom_range(0, 3) == 0) begin
                    new_payload(i);
                    r_req[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic run_idle(input int maxc);
        int n = 0;
        while ((any_req() || cyc < t_ackc) && n < maxc) begin
            step();
            n++;
        end
        chk("drain_bound", (any_req() || cyc < t_ackc), 1'b0);
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            r_req[i] = 1'b0; r_we[i] = 1'b0; r_addr[i] = '0; r_wdata[i] = '0;
        end
        drive_ports();
        mem_ack = 1'b0;
        #1;
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_ack", ack, 3'b000);
        chk("rst_err", err, 1'b0);
        chk("rst_rdata", rdata, 16'h0000);
        chk("rst_state", dbg_state, 3'b001);
        chk("rst_need_wait", need_wait, 1'b0);
        t_start = -100; t_len = 0; t_ackc = -100; t_ackin = -1;
        next_free = 0; last_g = 2; exp_rdata = '0;
        dly_q.delete(); rd_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        int exp_order[6] = '{0, 1, 2, 0, 1, 2};
        for (int i = 0; i < 3; i++) begin
            r_req[i] = 1'b0; r_we[i] = 1'b0; r_addr[i] = '0; r_wdata[i] = '0; pol[i] = 0;
        end
        mem_ack = 1'b0;
        mem_rdata = '0;
        drive_ports();
        do_reset();

        // Single fetch read with immediate mem_ack.
        r_addr[0] = 16'h0040; r_we[0] = 1'b0; r_req[0] = 1'b1;
        dly_q.push_back(0); rd_q.push_back(16'hBEEF);
        run_idle(40);
        chk("fetch_rdata", rdata, 16'hBEEF);

        // Data write with mem_ack after 4 wait cycles.
        r_addr[1] = 16'h1234; r_wdata[1] = 16'h5A5A; r_we[1] = 1'b1; r_req[1] = 1'b1;
        dly_q.push_back(4);
        run_idle(40);

        // Fetch attempting a write: must go out as a read.
        r_addr[0] = 16'h0044; r_wdata[0] = 16'hFFFF; r_we[0] = 1'b1; r_req[0] = 1'b1;
        dly_q.push_back(1);
        run_idle(40);

        // Debug read that never gets mem_ack, then the last-cycle boundary both ways.
        r_addr[2] = 16'h0ABC; r_we[2] = 1'b0; r_req[2] = 1'b1;
        dly_q.push_back(100);
        run_idle(40);
        chk("timeout_rdata", rdata, 16'h0000);
        r_req[2] = 1'b1; dly_q.push_back(TO - 1); rd_q.push_back(16'h1357);
        run_idle(40);
        chk("edge_ok_rdata", rdata, 16'h1357);
        r_req[2] = 1'b1; dly_q.push_back(TO);
        run_idle(40);

        // Data request rising during the RESP cycle of a fetch.
        r_addr[0] = 16'h0100; r_we[0] = 1'b0; r_req[0] = 1'b1;
        dly_q.push_back(2); dly_q.push_back(0);
        step();
        n = 0;
        while (cyc + 1 != t_ackc && n < 20) begin
            step();
            n++;
        end
        r_addr[1] = 16'h0200; r_we[1] = 1'b0; r_req[1] = 1'b1;
        run_idle(40);
        chk("late_req_grant", grants[grants.size()-1], 1);

        // Asynchronous reset in the middle of a debug access.
        r_addr[2] = 16'h0DDD; r_req[2] = 1'b1;
        dly_q.push_back(100);
        step(); step(); step();
        chk("pre_reset_busy", mem_req, 1'b1);
        do_reset();
        r_addr[1] = 16'h3333; r_req[1] = 1'b1;
        dly_q.push_back(0);
        run_idle(40);
        chk("post_reset_grant", grants[grants.size()-1], 1);

        // Contention from reset: all three held high.
        do_reset();
        grants.delete();
        for (int i = 0; i < 3; i++) begin
            new_payload(i); r_req[i] = 1'b1; pol[i] = 1;
        end
        n = 0;
        while (grants.size() < 6 && n < 200) begin
            step();
            n++;
        end
        chk("contention_count", grants.size() >= 6, 1'b1);
        for (int k = 0; k < 6; k++) begin
            if (grants.size() > k) chk("contention_order", grants[k], exp_order[k]);
        end
        for (int i = 0; i < 3; i++) pol[i] = 0;
        run_idle(100);

        // Random traffic.
        for (int i = 0; i < 3; i++) pol[i] = 2;
        rnd_on = 1'b1;
        repeat (800) step();
        rnd_on = 1'b0;
        for (int i = 0; i < 3; i++) pol[i] = 0;
        run_idle(200);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
